instruction_queue: RTL and testbench
====================================

Name: instruction_queue

Overview:
- Circular FIFO between the fetch/decode stage (instruction register) and dispatch to the reservation stations and ROB.
- Accepts one decoded control word plus its rvfi word per cycle using the ld_iq/iq_ack handshake.
- Presents the oldest entry to dispatch with a valid/ready handshake.
- Discards all contents on a branch-mispredict flush.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), width of the read and write pointers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_ip  in  1  mispredict flush; empties the queue.
- ld_iq  in  1  the upstream stage presents a valid control word.
- ctl_in  in  tomasula_types::ctl_word  decoded control word to enqueue.
- rvfi_in  in  rv32i_types::rvfi_word  debug word that travels with ctl_in.
- iq_ack  out  1  the word on ctl_in is accepted this cycle.
- issue_valid  out  1  the head entry is valid.
- issue_ready  in  1  dispatch consumes the head entry this cycle.
- ctl_out  out  tomasula_types::ctl_word  head control word.
- rvfi_out  out  rv32i_types::rvfi_word  head rvfi word.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: DEPTH-entry arrays for control words and rvfi words, write pointer wptr, read pointer rptr, occupancy counter cnt.
- Storage has no reset requirement; only the pointers and counter are reset.
- Reset (sync, rst=1 at a clock edge): wptr=0, rptr=0, cnt=0.
  - The cycle after reset: empty=1, full=0, count=0, issue_valid=0, iq_ack=0.
  - rst has priority over flush_ip, enqueue and dequeue.
- iq_ack is combinational: iq_ack = ld_iq & ~full & ~flush_ip & ~rst.
  - It must settle in the same cycle ld_iq rises, because upstream samples it in the same cycle it asserts ld_iq.
- Enqueue (enq = ld_iq & iq_ack):
  - Write ctl_in and rvfi_in at wptr.
  - wptr <= wptr+1, wrapping from DEPTH-1 to 0.
- Full does not admit an enqueue, even when a dequeue happens in the same cycle. iq_ack depends only on the registered full.
- Dequeue (deq = issue_valid & issue_ready & ~flush_ip):
  - rptr <= rptr+1, wrapping.
  - issue_ready while empty has no effect.
- issue_valid = ~empty.
- ctl_out and rvfi_out = array[rptr], combinational read of registered storage.
  - When empty, their values are don't-care.
- Counter:
  - cnt <= cnt + enq - deq.
  - Simultaneous enq and deq leaves cnt unchanged and advances both pointers.
- Flush (flush_ip=1, rst=0):
  - The next cycle has rptr=wptr=0, cnt=0.
  - No enqueue or dequeue occurs in the flush cycle.
  - iq_ack=0 and issue_valid stays at its pre-flush registered value during the flush cycle, but deq is suppressed.
  - A flush held for multiple cycles keeps the queue empty and iq_ack=0.
- Latency:
  - An entry enqueued at edge N is visible on ctl_out/issue_valid after edge N. No same-cycle bypass.
  - Minimum residency is 1 cycle.
- Ordering: strict FIFO; the rvfi word always stays paired with its control word.
- Throughput: one enqueue and one dequeue per cycle, sustained when the queue is neither full nor empty.
- Assertions the verifier checks:
  - cnt never exceeds DEPTH and never underflows.
  - full and empty are never both 1.
  - count == (wptr - rptr) mod DEPTH, except when full.

Test Plan:
1. Reset then hold ld_iq=1 with og_pc=0x60, 0x64, 0x68 on successive cycles and issue_ready=0 -> iq_ack=1 each cycle; count goes 1,2,3; ctl_out.og_pc=0x60.
2. Fill to DEPTH=8 with issue_ready=0, then assert ld_iq with og_pc=0x80 -> full=1, iq_ack=0. The next cycle assert issue_ready=1 -> head 0x60 leaves, count=7. The cycle after that, iq_ack=1 and 0x80 is accepted; the entries drain in order 0x64..0x80.
3. Wrap-around: stream 20 words with ld_iq=1 and issue_ready=1 every cycle -> count stays 1 after the first cycle; og_pc values come out in order with no drops or duplicates across pointer wrap 7->0.
4. Load 5 entries, then pulse flush_ip=1 for one cycle while ld_iq=1 and issue_ready=1 -> iq_ack=0 and no dequeue in the flush cycle. The next cycle has count=0, empty=1, issue_valid=0. The following enqueue of og_pc=0x200 becomes the head.
5. Assert rst=1 with 3 entries, ld_iq=1 and issue_ready=1 -> iq_ack=0 during reset; the next cycle has count=0 and empty=1.
6. Check rvfi pairing: enqueue rvfi.inst=0x00500093 with ctl.og_pc=0x60, then 0x00A00113 with 0x64 -> on dequeue, each rvfi_out.inst matches its ctl_out.og_pc.

Source files
------------

// File: rtl/rv32i_types.sv
// Retirement debug word that travels alongside each instruction.
package rv32i_types;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rvfi_word;

endpackage

// File: rtl/tomasula_types.sv
// Decoded control word carried from decode to dispatch.
package tomasula_types;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] og_pc;
  } ctl_word;

endpackage

// File: rtl/instruction_queue.sv
// Circular FIFO between decode and dispatch; holds control words paired with
// their rvfi words and drops everything on a mispredict flush.
module instruction_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_ip,
  input  logic                    ld_iq,
  input  tomasula_types::ctl_word ctl_in,
  input  rv32i_types::rvfi_word   rvfi_in,
  output logic                    iq_ack,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output tomasula_types::ctl_word ctl_out,
  output rv32i_types::rvfi_word   rvfi_out,
  output logic [PTR_W:0]          count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned CNT_W = PTR_W + 1;

  tomasula_types::ctl_word ctl_mem [DEPTH];
  rv32i_types::rvfi_word   rvfi_mem[DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq, deq;

  assign full        = (cnt_q == CNT_W'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign count       = cnt_q;
  assign issue_valid = ~empty;

  // Acceptance looks only at the registered full flag: no pass-through on full.
  assign iq_ack = ld_iq & ~full & ~flush_ip & ~rst;
  assign enq    = ld_iq & iq_ack;
  assign deq    = issue_valid & issue_ready & ~flush_ip & ~rst;

  assign ctl_out  = ctl_mem[rptr_q];
  assign rvfi_out = rvfi_mem[rptr_q];

  // Storage carries no reset; only pointers and occupancy are initialised.
  always_ff @(posedge clk) begin
    if (enq) begin
      ctl_mem[wptr_q]  <= ctl_in;
      rvfi_mem[wptr_q] <= rvfi_in;
    end
  end

  // Next pointer/occupancy state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_ip) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PTR_W'(1);
      if (deq) rptr_d = rptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed plus randomized bench for instruction_queue against a queue-based
// reference of the FIFO contract.
module tb_instruction_queue;
  import tomasula_types::*;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst, flush_ip, ld_iq, issue_ready;
  ctl_word          ctl_in, ctl_out;
  rvfi_word         rvfi_in, rvfi_out;
  logic             iq_ack, issue_valid, full, empty;
  logic [PTR_W:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  logic ack_seen;

  ctl_word  mq_ctl[$];
  rvfi_word mq_rv[$];

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_ip(flush_ip), .ld_iq(ld_iq),
    .ctl_in(ctl_in), .rvfi_in(rvfi_in), .iq_ack(iq_ack),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ctl_out(ctl_out), .rvfi_out(rvfi_out), .count(count),
    .full(full), .empty(empty)
  );

  function automatic ctl_word mk_ctl(input logic [31:0] pc);
    ctl_word c;
    c.op    = pc[5:2];
    c.rd    = pc[6:2];
    c.rs1   = pc[11:7];
    c.rs2   = ~pc[6:2];
    c.imm   = pc ^ 32'hA5A5_0000;
    c.og_pc = pc;
    return c;
  endfunction

  function automatic rvfi_word mk_rv(input logic [31:0] inst, input logic [31:0] pc);
    rvfi_word r;
    r.inst     = inst;
    r.pc_rdata = pc;
    r.pc_wdata = pc + 32'd4;
    r.rd_addr  = inst[11:7];
    r.rd_wdata = inst ^ pc;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check against the model mid-cycle, then advance the model.
  task automatic cycle(input logic l, input logic [31:0] pc, input logic [31:0] inst,
                       input logic r, input logic f, input logic rs);
    int   sz;
    logic exp_full, exp_ack, exp_valid;
    #1;
    ld_iq = l; ctl_in = mk_ctl(pc); rvfi_in = mk_rv(inst, pc);
    issue_ready = r; flush_ip = f; rst = rs;
    #1;
    sz        = mq_ctl.size();
    exp_full  = (sz == DEPTH);
    exp_ack   = l && !exp_full && !f && !rs;
    exp_valid = (sz != 0);
    ack_seen  = iq_ack;
    chk("iq_ack",      256'(iq_ack),      256'(exp_ack));
    chk("issue_valid", 256'(issue_valid), 256'(exp_valid));
    chk("count",       256'(count),       256'(sz));
    chk("full",        256'(full),        256'(exp_full));
    chk("empty",       256'(empty),       256'(sz == 0));
    chk("full_and_empty", 256'(full && empty), 256'(0));
    chk("count_bound", 256'(count <= (PTR_W+1)'(DEPTH)), 256'(1));
    if (exp_valid) begin
      chk("ctl_out",  256'(ctl_out),  256'(mq_ctl[0]));
      chk("rvfi_out", 256'(rvfi_out), 256'(mq_rv[0]));
    end
    @(posedge clk);
    if (rs || f) begin
      mq_ctl.delete();
      mq_rv.delete();
    end else begin
      if (exp_valid && r) begin
        void'(mq_ctl.pop_front());
        void'(mq_rv.pop_front());
      end
      if (exp_ack) begin
        mq_ctl.push_back(mk_ctl(pc));
        mq_rv.push_back(mk_rv(inst, pc));
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush_ip = 1'b0; ld_iq = 1'b0; issue_ready = 1'b0;
    ctl_in = mk_ctl(32'h0); rvfi_in = mk_rv(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_empty", 256'(empty), 256'(1));
    chk("rst_full",  256'(full),  256'(0));
    chk("rst_valid", 256'(issue_valid), 256'(0));
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_ack", 256'(ack_seen), 256'(0));

    // Basic enqueue with dispatch stalled.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h60 + 32'(4*i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("t1_ack", 256'(ack_seen), 256'(1));
      #1 chk("t1_count", 256'(count), 256'(i + 1));
    end
    chk("t1_head", 256'(ctl_out.og_pc), 256'(32'h60));

    // Fill, reject on full even alongside a dequeue, then accept.
    for (int i = 3; i < 8; i++)
      cycle(1'b1, 32'h60 + 32'(4*i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h80, 32'h2080, 1'b0, 1'b0, 1'b0);
    chk("t2_ack_full", 256'(ack_seen), 256'(0));
    #1 chk("t2_full", 256'(full), 256'(1));
    cycle(1'b1, 32'h80, 32'h2080, 1'b1, 1'b0, 1'b0);
    chk("t2_ack_full_deq", 256'(ack_seen), 256'(0));
    #1 chk("t2_count7", 256'(count), 256'(7));
    chk("t2_head", 256'(ctl_out.og_pc), 256'(32'h64));
    cycle(1'b1, 32'h80, 32'h2080, 1'b0, 1'b0, 1'b0);
    chk("t2_ack_after", 256'(ack_seen), 256'(1));
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 chk("t2_drained", 256'(empty), 256'(1));

    // Streaming across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'h100 + 32'(4*i), 32'h3000 + 32'(i), 1'b1, 1'b0, 1'b0);
      #1 chk("t3_count", 256'(count), 256'(1));
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with load and ready asserted.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h180 + 32'(4*i), 32'h4000 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h1f0, 32'h40ff, 1'b1, 1'b1, 1'b0);
    chk("t4_ack_flush", 256'(ack_seen), 256'(0));
    #1;
    chk("t4_count", 256'(count), 256'(0));
    chk("t4_empty", 256'(empty), 256'(1));
    chk("t4_valid", 256'(issue_valid), 256'(0));
    cycle(1'b1, 32'h200, 32'h4200, 1'b0, 1'b0, 1'b0);
    #1 chk("t4_head", 256'(ctl_out.og_pc), 256'(32'h200));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset beats load and dequeue.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h300 + 32'(4*i), 32'h5000 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3f0, 32'h50ff, 1'b1, 1'b0, 1'b1);
    chk("t5_ack_rst", 256'(ack_seen), 256'(0));
    #1;
    chk("t5_count", 256'(count), 256'(0));
    chk("t5_empty", 256'(empty), 256'(1));

    // rvfi stays paired with its control word.
    cycle(1'b1, 32'h60, 32'h00500093, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h64, 32'h00A00113, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t6_pc0",   256'(ctl_out.og_pc), 256'(32'h60));
    chk("t6_inst0", 256'(rvfi_out.inst), 256'(32'h00500093));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("t6_pc1",   256'(ctl_out.og_pc), 256'(32'h64));
    chk("t6_inst1", 256'(rvfi_out.inst), 256'(32'h00A00113));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 90) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
